// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee machine front end: selection codes,
// price lookup, coin values and the credit unit state encoding.
package coffee_pkg;

  typedef logic [2:0] coffee_type_t;

  localparam coffee_type_t CT_ESPRESSO   = 3'd0;
  localparam coffee_type_t CT_LUNGO      = 3'd1;
  localparam coffee_type_t CT_CAPPUCCINO = 3'd2;
  localparam coffee_type_t CT_LATTE      = 3'd3;
  localparam coffee_type_t CT_MOCHA      = 3'd4;

  localparam int COIN_100_VAL = 1;
  localparam int COIN_500_VAL = 5;

  typedef enum logic [1:0] {
    COLLECT,
    START,
    WAIT_ACK,
    BREWING
  } cc_state_t;

  // Codes above the last defined drink are not sold.
  function automatic logic coffee_valid(input coffee_type_t t);
    return t <= CT_MOCHA;
  endfunction

  // Price in 100-unit steps; invalid codes return 0 and must be gated by coffee_valid.
  function automatic logic [2:0] coffee_price(input coffee_type_t t);
    case (t)
      CT_ESPRESSO:   return 3'd1;
      CT_LUNGO:      return 3'd2;
      CT_CAPPUCCINO: return 3'd3;
      CT_LATTE:      return 3'd3;
      CT_MOCHA:      return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Conditions one raw switch: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each debounced 0->1 transition.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, flip the debounced level after DEBOUNCE_CYCLES disagreeing cycles, register the rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      level_q <= level;
      rise    <= level & ~level_q;
    end
  end

endmodule

// File: rtl/coin_credit_unit.sv
// Coffee machine front end: debounced coin/confirm events, saturating credit,
// price check with change, and a start/busy handshake toward the sequencer.
module coin_credit_unit
  import coffee_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CREDIT_W        = 4,
  parameter int MAX_CREDIT      = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_100,
  input  logic                coin_500,
  input  logic [2:0]          coffee_type,
  input  logic                confirm,
  input  logic                brew_busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic [2:0]          coffee_sel,
  output logic                brew_start,
  output logic                insufficient,
  output logic                overflow
);

  // One extra bit so credit + coin never wraps; at least wide enough for a 6-unit add.
  localparam int SUM_W = (CREDIT_W + 1 > 4) ? CREDIT_W + 1 : 4;

  logic                ev_100;
  logic                ev_500;
  logic                ev_confirm;
  cc_state_t           state;
  logic                coin_ev_p0;
  logic [SUM_W-1:0]    add_p0;
  logic [SUM_W-1:0]    sum_p0;
  logic [CREDIT_W-1:0] price_p0;
  logic                type_ok_p0;
  logic                afford_p0;

  function automatic logic credit_fits(input logic [SUM_W-1:0] s);
    return s <= SUM_W'(MAX_CREDIT);
  endfunction

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_100 (
    .clock(clock), .reset(reset), .raw(coin_100), .rise(ev_100)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_500 (
    .clock(clock), .reset(reset), .raw(coin_500), .rise(ev_500)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_confirm (
    .clock(clock), .reset(reset), .raw(confirm), .rise(ev_confirm)
  );

  // Stage p0: coin value, candidate credit and price check for the current cycle.
  always_comb begin
    add_p0 = '0;
    if (ev_100) add_p0 = add_p0 + SUM_W'(COIN_100_VAL);
    if (ev_500) add_p0 = add_p0 + SUM_W'(COIN_500_VAL);
    coin_ev_p0 = ev_100 | ev_500;
    sum_p0     = SUM_W'(credit) + add_p0;
    price_p0   = CREDIT_W'(coffee_price(coffee_type));
    type_ok_p0 = coffee_valid(coffee_type);
    afford_p0  = type_ok_p0 && (credit >= price_p0);
  end

  // Vend FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= COLLECT;
      credit       <= '0;
      change       <= '0;
      coffee_sel   <= '0;
      brew_start   <= 1'b0;
      insufficient <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      brew_start <= 1'b0;
      overflow   <= 1'b0;
      if (state != COLLECT && coin_ev_p0) overflow <= 1'b1;
      case (state)
        COLLECT: begin
          if (ev_confirm && afford_p0) begin
            change       <= credit - price_p0;
            coffee_sel   <= coffee_type;
            credit       <= '0;
            insufficient <= 1'b0;
            brew_start   <= 1'b1;
            state        <= START;
            if (coin_ev_p0) overflow <= 1'b1;
          end else begin
            if (coin_ev_p0) begin
              if (credit_fits(sum_p0)) begin
                credit       <= sum_p0[CREDIT_W-1:0];
                change       <= '0;
                insufficient <= 1'b0;
              end else begin
                overflow <= 1'b1;
              end
            end
            // A refused confirm is the newest information, so it wins the flag.
            if (ev_confirm) insufficient <= 1'b1;
          end
        end
        START:    state <= WAIT_ACK;
        WAIT_ACK: if (brew_busy) state <= BREWING;
        BREWING:  if (!brew_busy) state <= COLLECT;
        default:  state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/coin_credit_unit.md
Name: coin_credit_unit

Overview:
- Front-end stage of the coffee machine. Sits between the raw user switches and the brewing sequencer FSM.
- Synchronises and debounces the coin and confirm switches, and turns switch rises into single coin events.
- Accumulates a saturating credit in 100-unit steps. On confirm, checks the credit against the selected coffee's price and computes change.
- Hands a validated, latched coffee selection to the sequencer through a start/busy handshake.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a debounced input changes (must be >= 1).
- CREDIT_W, 4: width of the credit and change buses, in 100-unit steps.
- MAX_CREDIT, 15: saturation ceiling for credit (must be <= 2^CREDIT_W-1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_100  in  1  raw switch; each debounced rise is worth 1 unit
- coin_500  in  1  raw switch; each debounced rise is worth 5 units
- coffee_type  in  3  coffee selection code
- confirm  in  1  raw switch; a debounced rise requests a vend
- brew_busy  in  1  from the sequencer; high while brewing
- credit  out  CREDIT_W  current accumulated credit
- change  out  CREDIT_W  change from the last vend
- coffee_sel  out  3  selection latched at vend
- brew_start  out  1  one-cycle vend request
- insufficient  out  1  sticky: the last confirm was refused
- overflow  out  1  one-cycle pulse: a coin was rejected

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0; state is COLLECT.
  - Synchronisers, debounced values and edge registers are all 0.
  - Reset asserted in any state aborts the operation immediately. No brew_start follows.
- Input conditioning, identical for coin_100, coin_500 and confirm:
  - 2-flop synchroniser.
  - Debounced value flips only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - An event is a 0->1 transition of the debounced value, one cycle wide.
  - Latency: a raw rise held stable is reflected in credit exactly DEBOUNCE_CYCLES+3 clock edges after the first edge that samples it high.
- Coin events in COLLECT:
  - add = 1 for coin_100, 5 for coin_500; 6 if both events occur in the same cycle.
  - If credit+add <= MAX_CREDIT: credit <= credit+add, insufficient <= 0.
  - Otherwise credit is unchanged and overflow pulses for 1 cycle. The coin is rejected as a whole; no partial credit.
  - Arithmetic is done CREDIT_W+1 bits wide, so there is no wrap.
- Coin events outside COLLECT are discarded and overflow pulses.
- Price table, indexed by coffee_type: 0->1, 1->2, 2->3, 3->3, 4->4. Codes 5-7 are invalid.
- FSM states: COLLECT, START, WAIT_ACK, BREWING.
  - COLLECT + confirm event, valid type, credit >= price:
    - change <= credit-price; coffee_sel <= coffee_type; credit <= 0; insufficient <= 0; go to START.
    - A coin event in that same cycle is rejected (overflow pulse).
  - COLLECT + confirm event with an invalid type or credit < price: insufficient <= 1, credit is kept, stay in COLLECT.
  - START: brew_start = 1 for exactly this cycle; go to WAIT_ACK.
  - WAIT_ACK: go to BREWING when brew_busy = 1; otherwise wait indefinitely.
  - BREWING: go to COLLECT when brew_busy = 0.
  - Confirm events outside COLLECT are ignored.
- change and coffee_sel hold until the next vend or reset. change clears to 0 on the first accepted coin after returning to COLLECT.
- brew_start is never asserted in two consecutive cycles.

Decomposition:
- Shared package coffee_pkg holds:
  - coffee_type_t (3-bit) and its codes;
  - the price lookup function;
  - the state enum cc_state_t {COLLECT, START, WAIT_ACK, BREWING};
  - coin value constants COIN_100_VAL = 1 and COIN_500_VAL = 5.
- One sub-module: input_debouncer (synchroniser, stability counter, rise pulse). It is parameterised by DEBOUNCE_CYCLES and instantiated three times.

Test Plan (DEBOUNCE_CYCLES = 4):
- coin_100 high for 10 cycles, then low -> credit goes 0->1 exactly 7 edges after first sampled high. A single overflow-free increment; no second count while held.
- coin_100 toggling every 2 cycles for 12 cycles (bounce), then stable high -> exactly one increment, to 1.
- Credit 12, coin_500 -> credit stays 12 and overflow pulses for 1 cycle. Then coin_100 -> credit 13.
- Credit 5, coffee_type = 2, confirm:
  - brew_start pulses once; change = 2, coffee_sel = 2, credit = 0.
  - Hold brew_busy low 5 cycles: the FSM stays in WAIT_ACK.
  - brew_busy 1 for 8 cycles, then 0: the FSM returns to COLLECT.
  - A coin inserted during BREWING -> overflow pulse, credit stays 0.
- Credit 1, coffee_type = 4, confirm -> insufficient = 1, no brew_start, credit 1. Next coin_100 -> credit 2, insufficient = 0. coffee_type = 6, confirm -> insufficient = 1.
- Credit 3, vend started, reset asserted in WAIT_ACK -> next cycle all outputs 0, COLLECT, no further brew_start.
